// File: rtl/hp_control_pkg.sv
// Shared game definitions: the HP FSM state encoding, default timing constants, and the HP-bar
// length helper.
package hp_control_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAlive,
    StHit,
    StDead
  } hp_state_e;

  localparam int unsigned DefMaxHp       = 5;
  localparam int unsigned DefHitCycles   = 108000000;
  localparam int unsigned DefBlinkCycles = 13500000;
  localparam int unsigned DefBarStep     = 40;

  localparam int unsigned HpW  = 4;
  localparam int unsigned BarW = 12;
  localparam int unsigned CntW = 28;

  // MAX_HP*BAR_STEP must fit in BarW bits; the product is truncated otherwise.
  function automatic logic [BarW-1:0] bar_len(input logic [HpW-1:0] hp, input int unsigned step);
    return BarW'(32'(hp) * step);
  endfunction

endpackage

// File: rtl/hp_control_hit_timer.sv
// Immunity timer for the HP FSM: the cycle counter for the hit window and the blink divider that
// drives the sprite-blink output.
module hp_control_hit_timer
  import hp_control_pkg::*;
#(
  parameter int unsigned HIT_CYCLES   = DefHitCycles,
  parameter int unsigned BLINK_CYCLES = DefBlinkCycles
) (
  input  logic pclk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire,
  output logic o_blink
);

  localparam logic [CntW-1:0] LastCnt   = CntW'(HIT_CYCLES - 1);
  localparam logic [CntW-1:0] LastBlink = CntW'(BLINK_CYCLES - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] r_blink_cnt;
  logic            r_blink;

  // Anything other than load or run means the FSM is outside HIT, so everything idles at zero.
  always_ff @(posedge pclk) begin
    if (rst || !(i_load || i_run)) begin
      r_cnt       <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (i_load) begin
      r_cnt       <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_blink_cnt == LastBlink) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign o_expire = (r_cnt == LastCnt);
  assign o_blink  = r_blink;

endmodule

// File: rtl/hp_control.sv
// Player HP controller: tracks hit points across a game, grants a timed immunity window after each
// hit, and flags game over once HP reaches zero.
module hp_control
  import hp_control_pkg::*;
#(
  parameter int unsigned MAX_HP       = DefMaxHp,
  parameter int unsigned HIT_CYCLES   = DefHitCycles,
  parameter int unsigned BLINK_CYCLES = DefBlinkCycles,
  parameter int unsigned BAR_STEP     = DefBarStep
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             damage_in,
  output logic [HpW-1:0]   hp_out,
  output logic [BarW-1:0]  hp_bar_len_out,
  output logic             hit_blink_out,
  output logic             game_over_out
);

  localparam logic [HpW-1:0]  HpMax  = HpW'(MAX_HP);
  localparam logic [BarW-1:0] BarMax = bar_len(HpMax, BAR_STEP);

  hp_state_e       r_state;
  logic [HpW-1:0]  r_hp;
  logic [BarW-1:0] r_bar;
  logic            r_game_over;

  logic w_expire;
  logic w_blink;
  logic w_hit_now;
  logic w_load;
  logic w_run;

  // The expiry edge of HIT behaves like ALIVE, so a still-held damage_in lands a new hit there.
  always_comb begin
    w_hit_now = damage_in && !start_in &&
                ((r_state == StAlive) || ((r_state == StHit) && w_expire));
    w_load    = w_hit_now && (r_hp > 4'd1);
    w_run     = !start_in && (r_state == StHit) && !w_expire;
  end

  hp_control_hit_timer #(
    .HIT_CYCLES  (HIT_CYCLES),
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_hit_timer (
    .pclk    (pclk),
    .rst     (rst),
    .i_load  (w_load),
    .i_run   (w_run),
    .o_expire(w_expire),
    .o_blink (w_blink)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_hp        <= HpMax;
      r_bar       <= BarMax;
      r_game_over <= 1'b0;
    end else if (start_in) begin
      r_state     <= StAlive;
      r_hp        <= HpMax;
      r_bar       <= BarMax;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
        end
        StAlive, StHit: begin
          if (w_hit_now) begin
            if (r_hp > 4'd1) begin
              r_state <= StHit;
              r_hp    <= r_hp - 4'd1;
              r_bar   <= bar_len(r_hp - 4'd1, BAR_STEP);
            end else begin
              r_state <= StDead;
              r_hp    <= '0;
              r_bar   <= '0;
            end
          end else if ((r_state == StHit) && w_expire) begin
            r_state <= StAlive;
          end
        end
        StDead: begin
          // Game over trails the final HP drop by one edge.
          r_game_over <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign hp_out         = r_hp;
  assign hp_bar_len_out = r_bar;
  assign hit_blink_out  = w_blink;
  assign game_over_out  = r_game_over;

endmodule

// File: tb/tb_hp_control.sv
// Bench for hp_control: a hand-computed vector table, a held-damage sequence, DEAD handling, and
// random stimulus checked against a behavioural game model.
module tb_hp_control;

  localparam int unsigned MaxHp   = 3;
  localparam int unsigned HitCyc  = 8;
  localparam int unsigned BlinkCy = 2;
  localparam int unsigned Step    = 40;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic        damage_in = 1'b0;
  logic [3:0]  hp_out;
  logic [11:0] hp_bar_len_out;
  logic        hit_blink_out;
  logic        game_over_out;

  int total = 0;
  int bad = 0;

  // Behavioural model: game phase flags, HP, and age of the current immunity window.
  bit m_idle, m_dead, m_hit, m_go;
  int m_hp, m_age;

  hp_control #(
    .MAX_HP      (MaxHp),
    .HIT_CYCLES  (HitCyc),
    .BLINK_CYCLES(BlinkCy),
    .BAR_STEP    (Step)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .start_in      (start_in),
    .damage_in     (damage_in),
    .hp_out        (hp_out),
    .hp_bar_len_out(hp_bar_len_out),
    .hit_blink_out (hit_blink_out),
    .game_over_out (game_over_out)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit r;
    bit s;
    bit d;
    int hp;
    int bar;
    int blink;
    int go;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int hp, input int bar, input int bl, input int go);
    chk({tag, ".hp"}, int'(hp_out), hp);
    chk({tag, ".bar"}, int'(hp_bar_len_out), bar);
    chk({tag, ".blink"}, int'(hit_blink_out), bl);
    chk({tag, ".game_over"}, int'(game_over_out), go);
  endtask

  task automatic model_step(input bit r, input bit s, input bit d);
    if (r) begin
      m_idle = 1; m_dead = 0; m_hit = 0; m_go = 0; m_hp = MaxHp; m_age = 0;
    end else if (s) begin
      m_idle = 0; m_dead = 0; m_hit = 0; m_go = 0; m_hp = MaxHp; m_age = 0;
    end else if (m_idle) begin
    end else if (m_dead) begin
      m_go = 1;
    end else if (m_hit && m_age < HitCyc - 1) begin
      m_age++;
    end else if (d) begin
      if (m_hp > 1) begin
        m_hp--; m_hit = 1; m_age = 0;
      end else begin
        m_hp = 0; m_dead = 1; m_hit = 0;
      end
    end else begin
      m_hit = 0;
    end
  endtask

  function automatic int model_blink();
    return m_hit ? (((m_age / BlinkCy) % 2 == 0) ? 1 : 0) : 0;
  endfunction

  task automatic drive(input bit r, input bit s, input bit d);
    @(negedge pclk);
    rst = r; start_in = s; damage_in = d;
    @(posedge pclk);
    #1;
    model_step(r, s, d);
  endtask

  task automatic cyc_model(input string tag, input bit r, input bit s, input bit d);
    drive(r, s, d);
    chk_all(tag, m_hp, m_hp * Step, model_blink(), int'(m_go));
  endtask

  vec_t vecs[$];

  initial begin
    // Hand-derived expectations, one row per clock edge.
    vecs.push_back('{1, 0, 0, 3, 120, 0, 0});  // reset
    vecs.push_back('{0, 0, 1, 3, 120, 0, 0});  // damage ignored in IDLE
    vecs.push_back('{0, 1, 0, 3, 120, 0, 0});  // start
    vecs.push_back('{0, 0, 1, 2,  80, 1, 0});  // hit, HIT age 0
    vecs.push_back('{0, 0, 0, 2,  80, 1, 0});
    vecs.push_back('{0, 0, 1, 2,  80, 0, 0});  // damage ignored in HIT
    vecs.push_back('{0, 0, 0, 2,  80, 0, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 1, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 1, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 0, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 0, 0});  // age 7
    vecs.push_back('{0, 0, 0, 2,  80, 0, 0});  // expiry -> ALIVE
    vecs.push_back('{0, 1, 1, 3, 120, 0, 0});  // start beats damage
    vecs.push_back('{0, 0, 1, 2,  80, 1, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 1, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 0, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 0, 0});
    vecs.push_back('{0, 0, 0, 2,  80, 1, 0});  // HIT age 4
    vecs.push_back('{1, 0, 1, 3, 120, 0, 0});  // reset mid-HIT
    vecs.push_back('{0, 1, 0, 3, 120, 0, 0});
    vecs.push_back('{0, 0, 1, 2,  80, 1, 0});
    vecs.push_back('{0, 1, 0, 3, 120, 0, 0});  // start during HIT
    vecs.push_back('{0, 0, 0, 3, 120, 0, 0});  // plain ALIVE, no blink

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].hp, vecs[i].bar, vecs[i].blink, vecs[i].go);
    end

    // Damage held for 20 cycles from a fresh game.
    drive(1, 0, 0);
    drive(0, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc_model($sformatf("hold%0d", k), 0, 0, 1);
      if (k == 1) chk("hold.hp_c1", int'(hp_out), 2);
      if (k == 8) chk("hold.hp_c8", int'(hp_out), 2);
      if (k == 9) chk("hold.hp_c9", int'(hp_out), 1);
      if (k == 17) chk("hold.hp_c17", int'(hp_out), 0);
      if (k == 17) chk("hold.go_c17", int'(game_over_out), 0);
      if (k == 18) chk("hold.go_c18", int'(game_over_out), 1);
    end

    // DEAD: damage has no effect, start revives.
    cyc_model("dead_dmg0", 0, 0, 1);
    cyc_model("dead_idle", 0, 0, 0);
    cyc_model("dead_dmg1", 0, 0, 1);
    chk("dead.hp", int'(hp_out), 0);
    chk("dead.go", int'(game_over_out), 1);
    drive(0, 1, 0);
    chk_all("revive", 3, 120, 0, 0);

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      bit r, s, d;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 29) == 0);
      d = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 25 : 70));
      cyc_model($sformatf("rnd%0d", n), r, s, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hp_control.md
HP_CONTROL -- requirements
Module: hp_control

Interface
REQ-001 Parameter MAX_HP, 5, HP loaded at game start (1..15).
REQ-002 Parameter HIT_CYCLES, 108000000, immunity window after a hit, in pclk cycles (1 s at 108 MHz).
REQ-003 Parameter BLINK_CYCLES, 13500000, half-period of the hit blink, in pclk cycles.
REQ-004 Parameter BAR_STEP, 40, HP-bar pixels per HP point.
REQ-005 pclk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start_in  in  1  one-cycle request to (re)start a game.
REQ-008 damage_in  in  1  hit pulse from colision_detector.
REQ-009 hp_out  out  4  current HP, unsigned.
REQ-010 hp_bar_len_out  out  12  hp_out*BAR_STEP, HP-bar length in pixels.
REQ-011 hit_blink_out  out  1  player-sprite blink enable during immunity.
REQ-012 game_over_out  out  1  high while HP is zero after a game was played.

Function
REQ-013 States: IDLE, ALIVE, HIT, DEAD; all outputs registered, updated on the pclk edge after the causing input is sampled (1-cycle latency).
REQ-014 IDLE: hp_out=MAX_HP, blink=0, game_over=0; start_in -> ALIVE; damage_in ignored.
REQ-015 ALIVE, damage_in=1 and hp_out>1: hp_out decrements by 1, counter clears, -> HIT.
REQ-016 ALIVE, damage_in=1 and hp_out=1: hp_out=0, -> DEAD, game_over_out=1 from the next edge.
REQ-017 HIT: damage_in ignored (no decrement); counter increments each cycle; when counter=HIT_CYCLES-1 -> ALIVE with counter cleared.
REQ-018 HIT: hit_blink_out toggles every BLINK_CYCLES cycles, starting at 1 on HIT entry; forced to 0 on leaving HIT.
REQ-019 DEAD: hp_out=0, game_over_out=1, damage_in ignored; start_in -> ALIVE with hp_out=MAX_HP, game_over_out=0.
REQ-020 start_in in ALIVE or HIT: hp_out reloads to MAX_HP, counter and blink clear, -> ALIVE.
REQ-021 start_in and damage_in both high in the same cycle: start_in wins; no decrement.
REQ-022 damage_in held high for several cycles counts as one hit (second decrement only possible after HIT expires and damage_in is still high).
REQ-023 hp_out never underflows below 0 or exceeds MAX_HP.
REQ-024 hp_bar_len_out = hp_out*BAR_STEP computed in 12 bits, registered in the same cycle as hp_out; MAX_HP*BAR_STEP <= 4095 is a parameter-legality rule.
REQ-025 Counter width 28 bits; no wrap in any legal configuration.

Reset
REQ-026 rst=1 at a pclk edge: state=IDLE, hp_out=MAX_HP, hp_bar_len_out=MAX_HP*BAR_STEP, hit_blink_out=0, game_over_out=0, counters=0.
REQ-027 rst takes priority over start_in and damage_in; reset in mid-HIT abandons immunity immediately.

Structure
REQ-028 State encoding and default MAX_HP/HIT_CYCLES/BLINK_CYCLES constants live in the shared game package, shared with colision_detector's timing.
REQ-029 Single flat module; optional sub-module hit_timer (counter + blink divider) is the natural split.

Verification (MAX_HP=3, HIT_CYCLES=8, BLINK_CYCLES=2, BAR_STEP=40)
REQ-030 Reset then start_in pulse -> ALIVE, hp_out=3, hp_bar_len_out=120, game_over_out=0.
REQ-031 damage_in pulse in ALIVE -> hp_out=2, bar=80 after 1 cycle; blink 1,1,0,0,1,1,0,0 over 8 cycles, then 0 and ALIVE.
REQ-032 damage_in held high 20 cycles -> hp_out 3->2 at cycle 1, 2->1 at cycle 9, 1->0 at cycle 17, game_over_out=1 from cycle 18.
REQ-033 start_in and damage_in together in ALIVE with hp_out=2 -> hp_out=3, no HIT entry.
REQ-034 In DEAD: damage_in pulses -> no change; start_in -> hp_out=3, game_over_out=0.
REQ-035 rst asserted at HIT cycle 4 -> next cycle IDLE, hp_out=3, blink=0.
